alarm_bank_setter: RTL and testbench

Parametrised successor to the single-alarm setter. Holds `NUM_ALARMS` independent HH:MM alarms, edits one at a time through a two-button mode/increment interface, and compares every enabled alarm against the running clock. It sits between the button conditioning logic and the display/buzzer path, in parallel with the timekeeping counter.

---
 rtl/alarm_pkg.sv | 33 +++
 rtl/alarm_bank_setter_button_edge.sv | 18 +
 rtl/alarm_bank_setter.sv | 178 +++++++++++++++++
 tb/tb_alarm_bank_setter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state codes, digit limits, alarm record and match helper for the alarm bank setter.
package alarm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SEL   = 3'd1;
  localparam state_t ST_HL    = 3'd2;
  localparam state_t ST_HR    = 3'd3;
  localparam state_t ST_ML    = 3'd4;
  localparam state_t ST_MR    = 3'd5;
  localparam state_t ST_ONOFF = 3'd6;

  localparam logic [1:0] HL_MAX    = 2'd2;
  localparam logic [3:0] HR_MAX    = 4'd9;
  localparam logic [3:0] HR_MAX_20 = 4'd3;
  localparam logic [2:0] ML_MAX    = 3'd5;
  localparam logic [3:0] MR_MAX    = 4'd9;

  typedef struct packed {
    logic [1:0] hl;
    logic [3:0] hr;
    logic [2:0] ml;
    logic [3:0] mr;
    logic       en;
  } alarm_t;

  function automatic logic time_match(alarm_t a, logic [1:0] hl, logic [3:0] hr,
                                      logic [2:0] ml, logic [3:0] mr);
    return a.en && (a.hl == hl) && (a.hr == hr) && (a.ml == ml) && (a.mr == mr);
  endfunction

endpackage

// File: rtl/alarm_bank_setter_button_edge.sv
// Registers one button level and emits a single-cycle pulse on its rising edge.
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/alarm_bank_setter.sv
// Multi-alarm HH:MM setter with edit FSM, committed bank and per-alarm ring flags.
// Optional snooze counters are built when ALARM_SNOOZE_EN is defined.
module alarm_bank_setter
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_alarm_en,
  input  logic                  mode_button,
  input  logic                  inc_button,
  input  logic                  stop_button,
`ifdef ALARM_SNOOZE_EN
  input  logic                  snooze_button,
`endif
  input  logic [1:0]            cur_hours_left,
  input  logic [3:0]            cur_hours_right,
  input  logic [2:0]            cur_minutes_left,
  input  logic [3:0]            cur_minutes_right,
  input  logic                  min_tick,
  output logic [1:0]            o_hours_left,
  output logic [3:0]            o_hours_right,
  output logic [2:0]            o_minutes_left,
  output logic [3:0]            o_minutes_right,
  output logic [IDX_W-1:0]      o_sel,
  output logic [2:0]            o_field,
  output logic [NUM_ALARMS-1:0] on_off_mask,
  output logic [NUM_ALARMS-1:0] alarm_ring,
  output logic                  ack_flag
);

  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_ALARMS - 1);

  state_t                  state;
  logic [IDX_W-1:0]        sel, sel_next;
  alarm_t                  bank [NUM_ALARMS];
  alarm_t                  shadow, shadow_inc, disp;
  logic                    ack;
  logic [NUM_ALARMS-1:0]   ring, ring_next;
  logic                    mode_p, inc_p, stop_p, commit;

  button_edge u_mode (.clk(clk), .rst(rst), .btn(mode_button), .press(mode_p));
  button_edge u_inc  (.clk(clk), .rst(rst), .btn(inc_button),  .press(inc_p));
  button_edge u_stop (.clk(clk), .rst(rst), .btn(stop_button), .press(stop_p));

  assign sel_next = (sel == SEL_LAST) ? '0 : sel + 1'b1;

  // Increment of the field being edited; HL reaching 2 pulls HR down to 3.
  always_comb begin
    shadow_inc = shadow;
    case (state)
      ST_HL: begin
        shadow_inc.hl = (shadow.hl >= HL_MAX) ? 2'd0 : shadow.hl + 2'd1;
        if (shadow_inc.hl == HL_MAX && shadow.hr > HR_MAX_20) shadow_inc.hr = HR_MAX_20;
      end
      ST_HR:    shadow_inc.hr = (shadow.hr >= ((shadow.hl == HL_MAX) ? HR_MAX_20 : HR_MAX))
                                ? 4'd0 : shadow.hr + 4'd1;
      ST_ML:    shadow_inc.ml = (shadow.ml >= ML_MAX) ? 3'd0 : shadow.ml + 3'd1;
      ST_MR:    shadow_inc.mr = (shadow.mr >= MR_MAX) ? 4'd0 : shadow.mr + 4'd1;
      ST_ONOFF: shadow_inc.en = ~shadow.en;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      shadow <= '0;
      ack    <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) bank[i] <= '0;
    end else begin
      ack <= 1'b0;
      if (!set_alarm_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state  <= ST_SEL;
            shadow <= bank[sel];
          end
          ST_SEL: begin
            if (mode_p) state <= ST_HL;
            else if (inc_p) begin
              sel    <= sel_next;
              shadow <= bank[sel_next];
            end
          end
          ST_HL, ST_HR, ST_ML, ST_MR: begin
            if (mode_p)     state  <= state + 3'd1;
            else if (inc_p) shadow <= shadow_inc;
          end
          ST_ONOFF: begin
            if (mode_p) begin
              state     <= ST_SEL;
              bank[sel] <= shadow;
              ack       <= 1'b1;
            end else if (inc_p) begin
              shadow <= shadow_inc;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign commit = set_alarm_en && (state == ST_ONOFF) && mode_p;

`ifdef ALARM_SNOOZE_EN
  logic       snooze_p;
  logic [3:0] snz      [NUM_ALARMS];
  logic [3:0] snz_next [NUM_ALARMS];

  button_edge u_snooze (.clk(clk), .rst(rst), .btn(snooze_button), .press(snooze_p));
`endif

  // Sets (match, snooze expiry) are applied first so that stop and disable take priority.
  always_comb begin
    ring_next = ring;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (min_tick && time_match(bank[i], cur_hours_left, cur_hours_right,
                                 cur_minutes_left, cur_minutes_right))
        ring_next[i] = 1'b1;
    end
`ifdef ALARM_SNOOZE_EN
    snz_next = snz;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (min_tick && snz[i] != 4'd0) begin
        snz_next[i] = snz[i] - 4'd1;
        if (snz[i] == 4'd1) ring_next[i] = 1'b1;
      end
      if (snooze_p && ring[i]) begin
        ring_next[i] = 1'b0;
        snz_next[i]  = 4'(SNOOZE_MIN);
      end
      if (stop_p) snz_next[i] = 4'd0;
    end
    if (commit && !shadow.en) snz_next[sel] = 4'd0;
`endif
    if (stop_p) ring_next = '0;
    if (commit && !shadow.en) ring_next[sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ring <= '0;
`ifdef ALARM_SNOOZE_EN
      for (int i = 0; i < NUM_ALARMS; i++) snz[i] <= 4'd0;
`endif
    end else begin
      ring <= ring_next;
`ifdef ALARM_SNOOZE_EN
      snz  <= snz_next;
`endif
    end
  end

  assign disp = (state == ST_IDLE) ? bank[sel] : shadow;

  always_comb begin
    on_off_mask = '0;
    for (int i = 0; i < NUM_ALARMS; i++) on_off_mask[i] = bank[i].en;
  end

  assign o_hours_left    = disp.hl;
  assign o_hours_right   = disp.hr;
  assign o_minutes_left  = disp.ml;
  assign o_minutes_right = disp.mr;
  assign o_sel           = sel;
  assign o_field         = state;
  assign alarm_ring      = ring;
  assign ack_flag        = ack;

endmodule

// File: tb/tb_alarm_bank_setter.sv
// Bench for alarm_bank_setter: directed table, hand sequences and random traffic vs a time-of-day model.
module tb_alarm_bank_setter;

  localparam int NA = 4;
  localparam int IW = 2;
  localparam int SN = 5;

  logic          clk = 1'b0;
  logic          rst_n, set_en, mode_b, inc_b, stop_b, mt;
  logic [1:0]    o_hl;
  logic [3:0]    o_hr;
  logic [2:0]    o_ml;
  logic [3:0]    o_mr;
  logic [IW-1:0] o_sel;
  logic [2:0]    o_field;
  logic [NA-1:0] mask, ring;
  logic          ack;
  int            ch, cm;
`ifdef ALARM_SNOOZE_EN
  logic          snz_b;
`endif

  always #5 clk = ~clk;

  alarm_bank_setter #(.NUM_ALARMS(NA), .SNOOZE_MIN(SN)) dut (
    .clk(clk), .rst(rst_n), .set_alarm_en(set_en),
    .mode_button(mode_b), .inc_button(inc_b), .stop_button(stop_b),
`ifdef ALARM_SNOOZE_EN
    .snooze_button(snz_b),
`endif
    .cur_hours_left(2'(ch / 10)), .cur_hours_right(4'(ch % 10)),
    .cur_minutes_left(3'(cm / 10)), .cur_minutes_right(4'(cm % 10)),
    .min_tick(mt),
    .o_hours_left(o_hl), .o_hours_right(o_hr), .o_minutes_left(o_ml), .o_minutes_right(o_mr),
    .o_sel(o_sel), .o_field(o_field), .on_off_mask(mask), .alarm_ring(ring), .ack_flag(ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: alarms as minute-of-day, shadow as plain hours/minutes integers.
  int m_state, m_sel, m_sh, m_sm;
  int m_bmin [NA];
  bit m_ben  [NA];
  bit m_sen, m_ack;
  bit [NA-1:0] m_ring;
  bit p_mode, p_inc, p_stop;
`ifdef ALARM_SNOOZE_EN
  int m_snz [NA];
  bit p_snz;
`endif

  task automatic model_update();
    bit mp, ip, sp, commit;
    bit [NA-1:0] nring;
    int t, o;
    if (!rst_n) begin
      m_state = 0; m_sel = 0; m_sh = 0; m_sm = 0; m_sen = 0; m_ack = 0; m_ring = '0;
      p_mode = 0; p_inc = 0; p_stop = 0;
      for (int i = 0; i < NA; i++) begin m_bmin[i] = 0; m_ben[i] = 0; end
`ifdef ALARM_SNOOZE_EN
      p_snz = 0;
      for (int i = 0; i < NA; i++) m_snz[i] = 0;
`endif
      return;
    end
    mp = mode_b && !p_mode; ip = inc_b && !p_inc; sp = stop_b && !p_stop;
    p_mode = mode_b; p_inc = inc_b; p_stop = stop_b;
    m_ack = 0;
    nring = m_ring;
    for (int i = 0; i < NA; i++)
      if (mt && m_ben[i] && m_bmin[i] == ch * 60 + cm) nring[i] = 1;
`ifdef ALARM_SNOOZE_EN
    begin
      bit zp;
      zp = snz_b && !p_snz; p_snz = snz_b;
      for (int i = 0; i < NA; i++) begin
        if (mt && m_snz[i] > 0) begin
          m_snz[i]--;
          if (m_snz[i] == 0) nring[i] = 1;
        end
        if (zp && m_ring[i]) begin nring[i] = 0; m_snz[i] = SN; end
        if (sp) m_snz[i] = 0;
      end
    end
`endif
    if (sp) nring = '0;
    commit = 0;
    if (!set_en) m_state = 0;
    else begin
      case (m_state)
        0: begin m_state = 1; m_sh = m_bmin[m_sel] / 60; m_sm = m_bmin[m_sel] % 60; m_sen = m_ben[m_sel]; end
        1: if (mp) m_state = 2;
           else if (ip) begin
             m_sel = (m_sel + 1) % NA;
             m_sh = m_bmin[m_sel] / 60; m_sm = m_bmin[m_sel] % 60; m_sen = m_ben[m_sel];
           end
        6: if (mp) begin commit = 1; m_state = 1; end
           else if (ip) m_sen = !m_sen;
        default: if (mp) m_state++;
          else if (ip) begin
            t = m_sh / 10; o = m_sh % 10;
            case (m_state)
              2: begin t = (t + 1) % 3; if (t == 2 && o > 3) o = 3; m_sh = t * 10 + o; end
              3: begin o = (o + 1) % ((t == 2) ? 4 : 10); m_sh = t * 10 + o; end
              4: m_sm = ((m_sm / 10 + 1) % 6) * 10 + m_sm % 10;
              default: m_sm = (m_sm / 10) * 10 + (m_sm % 10 + 1) % 10;
            endcase
          end
      endcase
    end
    if (commit) begin
      m_bmin[m_sel] = m_sh * 60 + m_sm; m_ben[m_sel] = m_sen; m_ack = 1;
      if (!m_sen) begin
        nring[m_sel] = 0;
`ifdef ALARM_SNOOZE_EN
        m_snz[m_sel] = 0;
`endif
      end
    end
    m_ring = nring;
  endtask

  task automatic step();
    int hh, mm;
    bit [NA-1:0] em;
    model_update();
    @(posedge clk); #1;
    hh = (m_state == 0) ? m_bmin[m_sel] / 60 : m_sh;
    mm = (m_state == 0) ? m_bmin[m_sel] % 60 : m_sm;
    for (int i = 0; i < NA; i++) em[i] = m_ben[i];
    chk("field", 32'(o_field), m_state);
    chk("sel", 32'(o_sel), m_sel);
    chk("disp", o_hl * 1000 + o_hr * 100 + o_ml * 10 + o_mr, hh * 100 + mm);
    chk("mask", 32'(mask), 32'(em));
    chk("ring", 32'(ring), 32'(m_ring));
    chk("ack", 32'(ack), 32'(m_ack));
  endtask

  task automatic press(input bit m, input bit i);
    mode_b = m; inc_b = i; step();
    mode_b = 0; inc_b = 0; step();
  endtask

  task automatic press_n(input bit m, input bit i, input int n);
    for (int k = 0; k < n; k++) press(m, i);
  endtask

  // From SEL with a 00:00 disabled shadow: program h:m, optional enable, and commit.
  task automatic edit_current(input int h, input int m, input bit en);
    press(1, 0); press_n(0, 1, h / 10);
    press(1, 0); press_n(0, 1, h % 10);
    press(1, 0); press_n(0, 1, m / 10);
    press(1, 0); press_n(0, 1, m % 10);
    press(1, 0); if (en) press(0, 1);
    press(1, 0);
  endtask

  typedef struct {
    bit m; bit i; int reps;
    int field; int sel; int hl; int hr; int ml;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{0, 1, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 2, 3, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 9, 3, 1, 0, 9, 0};
    tbl[3]  = '{1, 0, 5, 2, 1, 0, 9, 0};
    tbl[4]  = '{0, 1, 1, 2, 1, 1, 9, 0};
    tbl[5]  = '{0, 1, 1, 2, 1, 2, 3, 0};
    tbl[6]  = '{1, 0, 1, 3, 1, 2, 3, 0};
    tbl[7]  = '{0, 1, 1, 3, 1, 2, 0, 0};
    tbl[8]  = '{0, 1, 3, 3, 1, 2, 3, 0};
    tbl[9]  = '{1, 0, 5, 2, 1, 2, 3, 0};
    tbl[10] = '{0, 1, 1, 2, 1, 0, 3, 0};
    tbl[11] = '{1, 0, 2, 4, 1, 0, 3, 0};
    tbl[12] = '{0, 1, 5, 4, 1, 0, 3, 5};
    tbl[13] = '{0, 1, 1, 4, 1, 0, 3, 0};

    rst_n = 0; set_en = 0; mode_b = 0; inc_b = 0; stop_b = 0; mt = 0; ch = 0; cm = 0;
`ifdef ALARM_SNOOZE_EN
    snz_b = 0;
`endif
    step(); step();
    rst_n = 1; step();
    chk("rst_field", 32'(o_field), 0);
    chk("rst_ring", 32'(ring), 0);
    chk("rst_mask", 32'(mask), 0);

    // First session: walk every field, commit alarm 0 unchanged.
    set_en = 1; step();
    chk("enter_sel", 32'(o_field), 1);
    for (int k = 0; k < 5; k++) begin
      press(1, 0);
      chk("walk_field", 32'(o_field), k + 2);
    end
    mode_b = 1; step();
    chk("commit_field", 32'(o_field), 1);
    chk("commit_ack", 32'(ack), 1);
    mode_b = 0; step();
    chk("ack_one_cycle", 32'(ack), 0);
    chk("bank0_after", 32'({o_hl, o_hr, o_ml, o_mr, mask[0]}), 0);

    // Digit wrap and clamp on alarm 1.
    for (int v = 0; v < 14; v++) begin
      press_n(tbl[v].m, tbl[v].i, tbl[v].reps);
      chk("tbl_field", 32'(o_field), tbl[v].field);
      chk("tbl_sel", 32'(o_sel), tbl[v].sel);
      chk("tbl_hl", 32'(o_hl), tbl[v].hl);
      chk("tbl_hr", 32'(o_hr), tbl[v].hr);
      chk("tbl_ml", 32'(o_ml), tbl[v].ml);
    end

    // Mode and inc together in HL: mode wins; then a held inc counts once.
    press_n(1, 0, 4);
    chk("simul_pre", 32'(o_field), 2);
    press(1, 1);
    chk("simul_field", 32'(o_field), 3);
    chk("simul_hl", 32'(o_hl), 0);
    inc_b = 1;
    for (int k = 0; k < 10; k++) step();
    inc_b = 0; step();
    chk("held_inc_hr", 32'(o_hr), 4);

    // Abort: 07:45 typed into alarm 2, enable dropped in MR.
    press_n(1, 0, 4);
    press(0, 1);
    press(1, 0); press(1, 0); press_n(0, 1, 7);
    press(1, 0); press_n(0, 1, 4);
    press(1, 0); press_n(0, 1, 5);
    chk("abort_shadow", o_hl * 1000 + o_hr * 100 + o_ml * 10 + o_mr, 745);
    set_en = 0; step();
    chk("abort_idle", 32'(o_field), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_bank2", o_hl * 1000 + o_hr * 100 + o_ml * 10 + o_mr, 0);

    // Match and stop: alarm 3 enabled 06:30, alarm 0 disabled 06:30.
    set_en = 1; step();
    press(0, 1);
    edit_current(6, 30, 1);
    chk("mask3", 32'(mask), 8);
    press(0, 1);
    chk("sel_wrap", 32'(o_sel), 0);
    edit_current(6, 30, 0);
    set_en = 0; step();
    ch = 6; cm = 30; mt = 1; step(); mt = 0;
    chk("ring3", 32'(ring), 8);
    stop_b = 1; step();
    chk("stop_clear", 32'(ring), 0);
    stop_b = 0; step();

`ifdef ALARM_SNOOZE_EN
    mt = 1; step(); mt = 0; step();
    chk("snz_ring", 32'(ring), 8);
    snz_b = 1; step();
    chk("snz_clear", 32'(ring), 0);
    snz_b = 0; step();
    cm = 31;
    for (int k = 1; k <= 5; k++) begin
      mt = 1; step(); mt = 0; step();
      chk("snz_count", 32'(ring), (k == 5) ? 8 : 0);
    end
    stop_b = 1; step(); stop_b = 0; step();
`endif

    // Reset in the middle of an edit.
    set_en = 1; step();
    press_n(1, 0, 2); press(0, 1);
    rst_n = 0; step();
    chk("mid_rst_field", 32'(o_field), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    rst_n = 1; step();

    // Random traffic, biased toward times that hit committed alarms.
    for (int c = 0; c < 2500; c++) begin
      set_en = ($urandom_range(0, 39) != 0);
      mode_b = ($urandom_range(0, 3) == 0);
      inc_b  = ($urandom_range(0, 2) == 0);
      stop_b = ($urandom_range(0, 29) == 0);
      mt     = ($urandom_range(0, 5) == 0);
`ifdef ALARM_SNOOZE_EN
      snz_b  = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, NA - 1);
        ch = m_bmin[k] / 60; cm = m_bmin[k] % 60;
      end else begin
        ch = $urandom_range(0, 23); cm = $urandom_range(0, 59);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
